// File: rtl/wb_arbiter.sv
// wb_arbiter
//
// Round-robin arbiter that merges N valid/ready requester streams into one
// registered output stream.
//
// Grant rules:
//   - A grant is issued only when the output register can take a new entry
//     (it is empty, or it drains on the same edge).
//   - The search starts at the round-robin pointer and wraps. The first
//     requester found with valid high wins.
//   - The pointer moves to one past the winner, and only on a real grant.
//
// Throughput and latency:
//   - Draining and loading on the same edge give one payload per cycle with
//     no bubbles.
//   - A payload accepted at edge k is visible on out_data after edge k.
//
// Ports:
//   clk        sole clock, rising-edge active
//   reset      synchronous active-high reset
//   req_valid  [N]      requester i presents a payload
//   req_ready  [N]      requester i's payload is accepted this cycle (one-hot or zero)
//   req_data   T x N    payload of requester i
//   out_valid           output register holds a payload
//   out_ready           consumer accepts the output this cycle
//   out_data   T        registered payload
//   out_src    [SW]     index of the requester that supplied out_data
module wb_arbiter #(
    parameter type T  = logic,
    parameter int  N  = 3,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [N-1:0]  req_valid,
    output logic [N-1:0]  req_ready,
    input  T              req_data [N],
    output logic          out_valid,
    input  logic          out_ready,
    output T              out_data,
    output logic [SW-1:0] out_src
);

    // Architectural state
    logic          out_valid_reg;
    T              out_data_reg;
    logic [SW-1:0] out_src_reg;
    logic [SW-1:0] ptr_reg;

    // Grant datapath
    logic          load_ok;
    logic          grant_en;
    logic [SW-1:0] grant_idx;
    logic [SW-1:0] ptr_next;
    T              grant_data;

    // cand_idx[k] is the requester visited k-th in the search from ptr_reg.
    // One extra bit keeps ptr+k from overflowing before the wrap.
    logic [SW:0]   cand_idx  [N];
    logic [N-1:0]  valid_rot;

    assign load_ok  = !out_valid_reg || out_ready;
    assign grant_en = !reset && load_ok && (|req_valid);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rotate
            logic [SW:0] rot_sum;
            assign rot_sum      = {1'b0, ptr_reg} + (SW+1)'(gi);
            assign cand_idx[gi] = (rot_sum >= (SW+1)'(N)) ? rot_sum - (SW+1)'(N) : rot_sum;
            // A shifted mask avoids index-width issues for non-power-of-two N.
            assign valid_rot[gi] = |(req_valid & (N'(1) << cand_idx[gi]));
        end
    endgenerate

    // Priority encode over the rotated order. Iterate from the far end so that
    // the closest candidate to ptr_reg wins.
    always_comb begin
        grant_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (valid_rot[k]) begin
                grant_idx = SW'(cand_idx[k]);
            end
        end
    end

    // Payload mux for the winner
    always_comb begin
        grant_data = req_data[0];
        for (int k = 1; k < N; k++) begin
            if (grant_idx == SW'(k)) begin
                grant_data = req_data[k];
            end
        end
    end

    assign ptr_next = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_ready
            assign req_ready[gi] = grant_en && (grant_idx == SW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_src_reg   <= '0;
            ptr_reg       <= '0;
        end else if (grant_en) begin
            // A load, either into an empty register or replacing a draining entry.
            out_valid_reg <= 1'b1;
            out_data_reg  <= grant_data;
            out_src_reg   <= grant_idx;
            ptr_reg       <= ptr_next;
        end else if (out_ready) begin
            // A drain with no replacement. data/src keep their last value.
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_src   = out_src_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// Testbench for wb_arbiter (N=3, 8-bit payload).
//
// Stimulus process:
//   - Drives directed vectors, each with a hand-computed req_ready value.
//   - Pushes the payload and source it expects to be loaded into a queue.
//
// Monitor process:
//   - Runs every cycle.
//   - Compares out_valid/out_data/out_src against the head of the queue.
//   - Pops the head when the consumer accepts it.
//
// Random phase:
//   - Requesters hold valid until granted.
//   - The bench checks one-hot grant, grant presence and fairness.
module tb_wb_arbiter;

    localparam int N = 3;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] src;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req_valid;
    logic [N-1:0] req_ready;
    logic [7:0]   req_data [N];
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic [1:0]   out_src;

    exp_t exp_q [$];
    int   n_vec  = 0;
    int   n_miss = 0;
    int   seq    = 1;

    wb_arbiter #(.T(logic [7:0]), .N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the queue head is the entry the output register must hold
    initial begin
        forever begin
            @(posedge clk);
            #2;
            check("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
            if (exp_q.size() != 0) begin
                check("out_data", {24'b0, out_data}, {24'b0, exp_q[0].data});
                check("out_src",  {30'b0, out_src},  {30'b0, exp_q[0].src});
                if (out_ready) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // One directed cycle. Called at +1 after a rising edge; returns at +1
    // after the next rising edge.
    task automatic cyc(input bit rst, input logic [2:0] v, input bit ordy, input logic [2:0] exp_rdy);
        exp_t e;
        reset     = rst;
        req_valid = v;
        out_ready = ordy;
        for (int i = 0; i < N; i++) begin
            req_data[i] = 8'(seq * 4 + i);
        end
        seq++;
        #2;
        check("req_ready", {29'b0, req_ready}, {29'b0, exp_rdy});
        $display("cyc rst=%0b valid=%b out_ready=%0b req_ready=%b exp=%b", rst, v, ordy, req_ready, exp_rdy);
        if (rst) begin
            exp_q.delete();
        end else if (exp_rdy != 3'b000) begin
            for (int i = 0; i < N; i++) begin
                if (exp_rdy[i]) begin
                    e.data = req_data[i];
                    e.src  = 2'(i);
                    exp_q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] pend;
        logic [7:0]   pdata [N];
        int           wait_cnt [N];
        bit           lok;
        int           g;
        exp_t         e;

        // Reset
        cyc(1, 3'b000, 0, 3'b000);
        cyc(1, 3'b111, 1, 3'b000);

        // All three requesting with out_ready high: 0,1,2,0,1,2
        cyc(0, 3'b111, 1, 3'b001);
        cyc(0, 3'b111, 1, 3'b010);
        cyc(0, 3'b111, 1, 3'b100);
        cyc(0, 3'b111, 1, 3'b001);
        cyc(0, 3'b111, 1, 3'b010);
        cyc(0, 3'b111, 1, 3'b100);

        // ptr=0 with requesters 1,2 -> 1, then all three -> 2
        cyc(0, 3'b110, 1, 3'b010);
        cyc(0, 3'b111, 1, 3'b100);

        // Load A from requester 0 (ptr -> 1), stall 4 cycles, then drain and reload
        cyc(0, 3'b001, 1, 3'b001);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 3'b001, 0, 3'b000);
        end
        cyc(0, 3'b001, 1, 3'b001);
        cyc(0, 3'b000, 1, 3'b000);

        // Requester 2 alone, back to back
        for (int i = 0; i < 5; i++) begin
            cyc(0, 3'b100, 1, 3'b100);
        end
        cyc(0, 3'b000, 1, 3'b000);

        // Empty register accepts even with out_ready low; full one does not
        cyc(0, 3'b010, 0, 3'b010);
        cyc(0, 3'b011, 0, 3'b000);
        cyc(0, 3'b011, 1, 3'b001);
        cyc(0, 3'b010, 1, 3'b010);
        cyc(0, 3'b000, 1, 3'b000);

        // Reset while holding a stalled entry
        cyc(0, 3'b100, 0, 3'b100);
        cyc(1, 3'b111, 0, 3'b000);
        cyc(1, 3'b111, 1, 3'b000);
        check("post_reset_out_valid", {31'b0, out_valid}, 32'd0);
        check("post_reset_out_src",   {30'b0, out_src},   32'd0);
        cyc(0, 3'b110, 0, 3'b010);
        cyc(0, 3'b111, 1, 3'b100);
        cyc(0, 3'b000, 1, 3'b000);

        // Random stress: valid held until granted
        pend = '0;
        for (int i = 0; i < N; i++) begin
            wait_cnt[i] = 0;
            pdata[i]    = '0;
        end
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i]  = 1'b1;
                    pdata[i] = 8'(seq);
                    seq++;
                end
            end
            reset     = 1'b0;
            req_valid = pend;
            for (int i = 0; i < N; i++) begin
                req_data[i] = pdata[i];
            end
            out_ready = ($urandom_range(0, 3) != 0);
            lok = (exp_q.size() == 0) || out_ready;
            #2;
            check("rdy_onehot",  {31'b0, $countones(req_ready) <= 1}, 32'd1);
            check("rdy_present", {31'b0, req_ready != 3'b000}, {31'b0, lok && (pend != 3'b000)});
            check("rdy_subset",  {29'b0, req_ready & ~pend}, 32'd0);
            g = -1;
            for (int i = 0; i < N; i++) begin
                if (req_ready[i] && $countones(req_ready) == 1) begin
                    g = i;
                end
            end
            if (g >= 0) begin
                e.data = pdata[g];
                e.src  = 2'(g);
                exp_q.push_back(e);
                $display("stress c=%0d grant=%0d data=%0h", c, g, pdata[g]);
                for (int i = 0; i < N; i++) begin
                    if (i != g && pend[i]) begin
                        wait_cnt[i]++;
                        check("fairness", {31'b0, wait_cnt[i] <= N - 1}, 32'd1);
                    end
                end
                pend[g]     = 1'b0;
                wait_cnt[g] = 0;
            end
            @(posedge clk);
            #1;
        end

        // Drain and confirm nothing left over
        for (int i = 0; i < 3; i++) begin
            cyc(0, 3'b000, 1, 3'b000);
        end
        check("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
